// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register peripheral: five 8-bit control registers loaded from
// 16-bit frames (R/W, 7-bit address, 8-bit data), all SPI pins resynchronised into clk.
module spi_reg_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic [SYNC_STAGES-1:0] sync_vld;

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sync_ok;
  logic sclk_prev;
  logic ncs_prev;
  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;

  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic        armed;
  logic        commit;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign copi_s  = copi_sync[SYNC_STAGES-1];
  assign ncs_s   = ncs_sync[SYNC_STAGES-1];
  assign sync_ok = sync_vld[SYNC_STAGES-1];

  // sync_vld marks when the chains hold real pin values; until then the reset
  // value of ncs must not be mistaken for a falling edge that re-arms the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sync_vld  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b0;
    end else if (sync_ok) begin
      sclk_prev <= sclk_s;
      ncs_prev  <= ncs_s;
    end
  end

  assign sclk_rise = sync_ok & sclk_s & ~sclk_prev;
  assign ncs_fall  = sync_ok & ~ncs_s & ncs_prev;
  assign ncs_rise  = sync_ok & ncs_s & ~ncs_prev;

  assign commit = ncs_rise & armed & (bit_cnt == 5'd16) & shift_reg[15]
                & (shift_reg[14:8] <= MAX_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 5'd0;
      shift_reg <= 16'h0000;
      armed     <= 1'b0;
    end else if (ncs_fall) begin
      bit_cnt   <= 5'd0;
      shift_reg <= 16'h0000;
      armed     <= 1'b1;
    end else if (ncs_rise) begin
      armed <= 1'b0;
    end else if (sclk_rise && !ncs_s && armed) begin
      shift_reg <= {shift_reg[14:0], copi_s};
      // Saturating so an overlong frame can never alias back to a count of 16.
      if (bit_cnt != 5'd17) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      wr_strobe       <= 1'b0;
    end else begin
      wr_strobe <= commit;
      if (commit) begin
        case (shift_reg[14:8])
          7'h00:   en_reg_out_7_0  <= shift_reg[7:0];
          7'h01:   en_reg_out_15_8 <= shift_reg[7:0];
          7'h02:   en_reg_pwm_7_0  <= shift_reg[7:0];
          7'h03:   en_reg_pwm_15_8 <= shift_reg[7:0];
          7'h04:   pwm_duty_cycle  <= shift_reg[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule
